// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: VGA scanout fetches take priority, the drawing port
// gets all remaining cycles, and the front buffer swaps at the start of vblank.
module vga_fb_arbiter #(
  parameter int PIX_W    = 8,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         cnt_h,
  input  logic [9:0]         cnt_v,
  output logic [PIX_W-1:0]   pix_data,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [17:0]        req_addr,
  input  logic [4*PIX_W-1:0] req_wdata,
  input  logic [3:0]         req_be,
  output logic               rsp_valid,
  output logic [4*PIX_W-1:0] rsp_rdata,
  input  logic               swap_req,
  output logic               front_buf,
  output logic               swap_done,
  output logic [17:0]        mem_addr,
  output logic               mem_we,
  output logic [3:0]         mem_be,
  output logic [4*PIX_W-1:0] mem_wdata,
  input  logic [4*PIX_W-1:0] mem_rdata
);

  localparam int WW = 4 * PIX_W;

  typedef enum logic {IDLE, PENDING} swap_state_t;

  swap_state_t   state, state_n;
  logic          swap_hit;
  logic          slot_line, slot_next, slot;
  logic          next_vis;
  logic [8:0]    disp_y;
  logic [7:0]    disp_g;
  logic          accept;
  logic          fetch_q;
  logic          rd_q;
  logic [WW-1:0] rdata_q;
  logic [WW-1:0] next_word, cur_word;
  logic [17:0]   addr_q;

  // Display slot decode: in-line prefetch of the following group, plus the
  // group-0 fetch for the next visible line near the end of each line.
  always_comb begin
    slot_line = (cnt_v < 10'(V_ACTIVE)) && (cnt_h[1:0] == 2'b00) &&
                (cnt_h <= 10'(H_ACTIVE - 8));
    next_vis  = (cnt_v < 10'(V_ACTIVE - 1)) || (cnt_v == 10'(V_TOTAL - 1));
    slot_next = (cnt_h == 10'(H_TOTAL - 4)) && next_vis;
    slot      = slot_line || slot_next;
    if (slot_next) begin
      disp_y = (cnt_v == 10'(V_TOTAL - 1)) ? 9'd0 : cnt_v[8:0] + 9'd1;
      disp_g = 8'd0;
    end else begin
      disp_y = cnt_v[8:0];
      disp_g = cnt_h[9:2] + 8'd1;
    end
  end

  assign req_ready = reset && !slot;
  assign accept    = req_valid && req_ready;

  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    if (slot) begin
      mem_addr = {front_buf, disp_y, disp_g};
    end else if (accept) begin
      mem_addr  = req_addr;
      mem_we    = req_we;
      mem_be    = req_be;
      mem_wdata = req_wdata;
    end
  end

  // Read data arrives combinationally the cycle after accept; the holding
  // register keeps it stable until the next read completes.
  assign rsp_valid = rd_q && reset;
  assign rsp_rdata = rsp_valid ? mem_rdata : rdata_q;

  always_comb begin
    pix_data = '0;
    if ((cnt_h < 10'(H_ACTIVE)) && (cnt_v < 10'(V_ACTIVE)))
      pix_data = cur_word[cnt_h[1:0]*PIX_W +: PIX_W];
  end

  always_comb begin
    state_n  = state;
    swap_hit = 1'b0;
    case (state)
      IDLE:    if (swap_req) state_n = PENDING;
      PENDING: if ((cnt_v == 10'(V_ACTIVE)) && (cnt_h == 10'd0)) begin
        state_n  = IDLE;
        swap_hit = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      front_buf <= 1'b0;
      swap_done <= 1'b0;
      fetch_q   <= 1'b0;
      rd_q      <= 1'b0;
      rdata_q   <= '0;
      next_word <= '0;
      cur_word  <= '0;
      addr_q    <= '0;
    end else begin
      state     <= state_n;
      front_buf <= front_buf ^ swap_hit;
      swap_done <= swap_hit;
      fetch_q   <= slot;
      rd_q      <= accept && !req_we;
      addr_q    <= mem_addr;
      if (fetch_q)
        next_word <= mem_rdata;
      if (cnt_h[1:0] == 2'b11)
        cur_word <= next_word;
      if (rd_q)
        rdata_q <= mem_rdata;
    end
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between VGA scanout and a drawing requester. Scanout fetches use the cnt_h/cnt_v counters from the VGA timing generator and always win. The drawing engine gets every remaining cycle through a valid/ready port. The block also owns double-buffer selection, swapping the front buffer at the start of vertical blanking on request.

Parameters:
PIX_W, 8, bits per pixel; RAM word = 4 pixels = 4*PIX_W bits, pixel 0 in the low byte lane
H_ACTIVE, 640, visible pixels per line
H_TOTAL, 800, clocks per line
V_ACTIVE, 480, visible lines
V_TOTAL, 525, lines per frame

Ports:
clk  in  1  pixel clock
reset  in  1  reset, synchronous, active-low
cnt_h  in  10  horizontal count from timing generator, +1 per clk, wraps at H_TOTAL-1
cnt_v  in  10  vertical count, +1 per line, wraps at V_TOTAL-1
pix_data  out  PIX_W  pixel for current (cnt_h,cnt_v), zero outside the active area
req_valid  in  1  drawing request valid
req_ready  out  1  request accepted when req_valid&&req_ready
req_we  in  1  1=write, 0=read
req_addr  in  18  word address {buf,y[8:0],g[7:0]}
req_wdata  in  4*PIX_W  write data
req_be  in  4  byte-lane enables for writes
rsp_valid  out  1  read data valid, 1 cycle after read accept
rsp_rdata  out  4*PIX_W  read data
swap_req  in  1  pulse: request front-buffer swap
front_buf  out  1  buffer currently scanned out
swap_done  out  1  1-cycle pulse when swap applied
mem_addr  out  18  RAM address (combinational)
mem_we  out  1  RAM write strobe (combinational)
mem_be  out  4  RAM byte enables
mem_wdata  out  4*PIX_W  RAM write data
mem_rdata  in  4*PIX_W  RAM read data, valid the cycle after address

Behaviour:
- Address layout: {buf, y, g}, where g = x/4 (0..159) and the line stride is 256 words. No multiplier.
- Display slot cycles are:
  - cnt_v<V_ACTIVE and cnt_h in {0,4,...,H_ACTIVE-8}: fetches group g=cnt_h/4+1 of line cnt_v.
  - cnt_h==H_TOTAL-4: fetches group 0 of the next line, only if the next line is visible. The next line is cnt_v+1 when cnt_v<V_ACTIVE-1, or 0 when cnt_v==V_TOTAL-1.
- In a display slot: mem_addr={front_buf,y,g}, mem_we=0, req_ready=0.
- Word pipeline:
  - Read data is captured into a next_word register on the following cycle.
  - On the clock edge ending the cycle with cnt_h[1:0]==3, next_word is copied to cur_word.
  - pix_data = cur_word lane cnt_h[1:0] when cnt_h<H_ACTIVE and cnt_v<V_ACTIVE, else 0.
  - Net effect: the pixel at x appears in the same cycle that cnt_h==x.
- Requester port:
  - req_ready=1 in every non-display-slot cycle with reset high.
  - On accept, mem_addr=req_addr, mem_we=req_we, mem_be=req_be, mem_wdata=req_wdata.
  - A read gives rsp_valid=1 and rsp_rdata=mem_rdata on the next cycle. rsp_rdata holds its value until the next read.
  - Writes produce no response. Throughput is 1/cycle; writes during active lines are limited to 3 of every 4 cycles.
- Idle cycles (no slot, no accept): mem_we=0, mem_be=0, mem_addr holds its previous value.
- Swap FSM has two states, IDLE and PENDING:
  - IDLE→PENDING on swap_req.
  - PENDING→IDLE on the cycle with cnt_v==V_ACTIVE and cnt_h==0. On that edge front_buf toggles and swap_done pulses for 1 cycle.
  - swap_req while PENDING is absorbed, so the swap happens once.
  - swap_req in the same cycle as the swap point with state IDLE sets PENDING, to be applied next frame.
- Reset (reset==0 at a clk edge):
  - Registered outputs clear: front_buf=0, swap_done=0, rsp_valid=0, rsp_rdata=0, cur_word=0, next_word=0; FSM goes to IDLE.
  - While reset==0: req_ready=0 and mem_we=0.
  - A read accepted in the cycle before reset asserts gets no rsp_valid.
  - Scanout resumes at the next display slot; pixels before the first fetched word show 0.

Test Plan:
- Reset: hold reset=0 for 3 clk with req_valid=1, swap_req=1 -> req_ready=0, mem_we=0, rsp_valid=0, swap_done=0, front_buf=0, pix_data=0; FSM IDLE after release.
- Scanout: RAM[0]=0x44332211, RAM[1]=0x88776655; run cnt_v=524,cnt_h=796 -> mem_addr=0, req_ready=0; at cnt_v=0, pix_data=0x11,0x22,0x33,0x44,0x55..0x88 for cnt_h=0..7; cnt_h=640 -> pix_data=0.
- Slot conflict: req_valid=1, write, addr=0x00123 at cnt_v=10,cnt_h=8 -> req_ready=0 at cnt_h=8 (mem_addr=0x00A03), accepted at cnt_h=9 with mem_we=1, mem_addr=0x00123.
- Read response: read addr 0x20005 at cnt_v=500 -> req_ready=1, rsp_valid=1 next cycle with RAM content; back-to-back reads give rsp_valid on consecutive cycles.
- Swap: swap_req pulses at cnt_v=100 and cnt_v=200 -> one toggle at cnt_v=480,cnt_h=0, front_buf=1, single swap_done pulse; at cnt_v=524,cnt_h=796 mem_addr=0x20000.
- Blanking edge: cnt_v=479,cnt_h=796 -> no display slot, req_ready=1; cnt_v=478,cnt_h=796 -> slot, mem_addr={front_buf,9'd479,8'd0}.
